la_dpram_fifoctrl: RTL and testbench

// - Single-clock FIFO controller driving one la_dpram instance (write port + read port on the same clock).
// - Converts a valid/ready push stream into RAM writes, prefetches RAM reads and hides the RAM's
//   1-cycle read latency behind a 2-entry output buffer.
// - The result is a show-ahead valid/ready pop stream at full throughput (1 word/cycle).
// - Sits upstream of la_dpram: owns pointers, flags and occupancy; the RAM only stores data.

---
 rtl/la_dpram_fifoctrl_if.sv | 38 +++
 rtl/la_dpram_fifoctrl.sv | 117 +++++++++++
 tb/tb_la_dpram_fifoctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/la_dpram_fifoctrl_if.sv
// rtl/la_dpram_fifoctrl_if.sv - push/pop streams, status and la_dpram port bundle for the FIFO controller
interface la_dpram_fifoctrl_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          clear;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_din;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_dout;
    logic [AW:0]   count;
    logic          ram_wr_ce;
    logic          ram_wr_we;
    logic [DW-1:0] ram_wr_wmask;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_din;
    logic          ram_rd_ce;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_dout;

    modport slave (
        input  clear, wr_valid, wr_din, rd_ready, ram_rd_dout,
        output wr_ready, rd_valid, rd_dout, count,
        output ram_wr_ce, ram_wr_we, ram_wr_wmask, ram_wr_addr, ram_wr_din,
        output ram_rd_ce, ram_rd_addr
    );

    modport master (
        output clear, wr_valid, wr_din, rd_ready, ram_rd_dout,
        input  wr_ready, rd_valid, rd_dout, count,
        input  ram_wr_ce, ram_wr_we, ram_wr_wmask, ram_wr_addr, ram_wr_din,
        input  ram_rd_ce, ram_rd_addr
    );
endinterface

// File: rtl/la_dpram_fifoctrl.sv
// rtl/la_dpram_fifoctrl.sv - single-clock FIFO controller for la_dpram with show-ahead 2-entry output buffer
module la_dpram_fifoctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    la_dpram_fifoctrl_if.slave    bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [AW:0]   r_count;
    logic          r_inflight;
    logic [1:0]    r_occ;
    logic          r_rd_valid;
    logic          r_wr_ready;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] r_skid;

    logic          w_push;
    logic          w_pop;
    logic          w_ram_ne;
    logic          w_issue;
    logic [2:0]    w_pending;
    logic [1:0]    w_occ_nxt;
    logic [AW:0]   w_count_nxt;

    // A write in a clear cycle is dropped so the RAM is left untouched
    assign w_push    = bus.wr_valid & r_wr_ready & ~bus.clear;
    assign w_pop     = (r_occ != 2'd0) & bus.rd_ready;
    assign w_ram_ne  = (r_wptr != r_rptr);
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = w_ram_ne & (w_pending < 3'd2) & ~bus.clear;
    assign w_occ_nxt = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + ONE;
        end else if (~w_push & w_pop) begin
            w_count_nxt = r_count - ONE;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b0;
        end else if (bus.clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ONE;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + ONE;
            end
            r_inflight <= w_issue;
            r_occ      <= w_occ_nxt;
            r_rd_valid <= (w_occ_nxt != 2'd0);
            r_count    <= w_count_nxt;
            r_wr_ready <= (w_count_nxt < FULL);
        end
    end

    // Returning RAM data lands in the head slot when it is free (or leaving), else in the skid slot
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dout <= '0;
            r_skid <= '0;
        end else if (!bus.clear) begin
            if (w_pop) begin
                if (r_occ == 2'd2) begin
                    r_dout <= r_skid;
                    if (r_inflight) begin
                        r_skid <= bus.ram_rd_dout;
                    end
                end else if (r_inflight) begin
                    r_dout <= bus.ram_rd_dout;
                end
            end else if (r_inflight) begin
                if (r_occ == 2'd0) begin
                    r_dout <= bus.ram_rd_dout;
                end else begin
                    r_skid <= bus.ram_rd_dout;
                end
            end
        end
    end

    assign bus.wr_ready     = r_wr_ready;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_dout      = r_dout;
    assign bus.count        = r_count;
    assign bus.ram_wr_ce    = w_push;
    assign bus.ram_wr_we    = w_push;
    assign bus.ram_wr_wmask = '1;
    assign bus.ram_wr_addr  = r_wptr[AW-1:0];
    assign bus.ram_wr_din   = bus.wr_din;
    assign bus.ram_rd_ce    = w_issue;
    assign bus.ram_rd_addr  = r_rptr[AW-1:0];
endmodule

// File: tb/tb_la_dpram_fifoctrl.sv
// tb/tb_la_dpram_fifoctrl.sv - randomized bench for la_dpram_fifoctrl against a queue-based FIFO model
module tb_la_dpram_fifoctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    la_dpram_fifoctrl_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    la_dpram_fifoctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    // Attached dual-port RAM: 1-cycle registered read, no bypass
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wr_ce && bus.ram_wr_we) mem[bus.ram_wr_addr] <= bus.ram_wr_din & bus.ram_wr_wmask;
        if (bus.ram_rd_ce) bus.ram_rd_dout <= mem[bus.ram_rd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted words tagged with their accept edge; a word is
    // visible at the head two edges after it was accepted
    typedef struct {
        logic [DW-1:0] d;
        int            ts;
    } ent_t;

    ent_t          mq[$];
    int            cyc = 0;
    bit            started = 1'b0;
    logic [DW-1:0] obs_d[$];
    int            obs_c[$];

    function automatic bit exp_ready();
        return started && (mq.size() < DEPTH);
    endfunction

    function automatic bit exp_valid();
        return started && (mq.size() > 0) && (mq[0].ts <= cyc - 2);
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mq.delete();
            started = 1'b0;
        end else begin
            bit   p;
            bit   q;
            ent_t e;
            p = bus.wr_valid && exp_ready();
            q = exp_valid() && bus.rd_ready;
            if (bus.rd_valid && bus.rd_ready) begin
                obs_d.push_back(bus.rd_dout);
                obs_c.push_back(cyc + 1);
            end
            cyc++;
            if (bus.clear) begin
                mq.delete();
            end else begin
                if (q) void'(mq.pop_front());
                if (p) begin
                    e.d  = bus.wr_din;
                    e.ts = cyc;
                    mq.push_back(e);
                end
            end
            started = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("wr_ready", bus.wr_ready, exp_ready());
        chk("rd_valid", bus.rd_valid, exp_valid());
        chk("count", bus.count, mq.size());
        chk("count_le_depth", bus.count <= DEPTH, 1);
        if (exp_valid()) chk("rd_dout", bus.rd_dout, mq[0].d);
    end

    task automatic drive(input logic wv, input logic [DW-1:0] din, input logic rr, input logic clr);
        @(negedge clk);
        #2;
        bus.wr_valid = wv;
        bus.wr_din   = din;
        bus.rd_ready = rr;
        bus.clear    = clr;
        #1;
        chk("ram_wr_ce", bus.ram_wr_ce, wv && exp_ready() && !clr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int bad;
        int pushes;
        int cycles;
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_din   = '0;
        bus.rd_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_rd_dout", bus.rd_dout, 0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) drive(0, 0, 0, 0);
        chk("wmask", bus.ram_wr_wmask, 32'hFFFF_FFFF);

        // Single word: visible exactly two edges after acceptance
        drive(1, 32'hA1, 1, 0);
        drive(0, 0, 1, 0);
        chk("a1_count1", bus.count, 1);
        chk("a1_valid_e0", bus.rd_valid, 0);
        drive(0, 0, 1, 0);
        chk("a1_valid_e1", bus.rd_valid, 0);
        drive(0, 0, 1, 0);
        chk("a1_valid_e2", bus.rd_valid, 1);
        chk("a1_dout", bus.rd_dout, 32'hA1);
        drive(0, 0, 0, 0);
        chk("a1_count0", bus.count, 0);

        // Fill to DEPTH, 17th push refused, one pop reopens
        repeat (18) drive(1, $urandom, 0, 0);
        drive(1, 32'hDEAD, 0, 0);
        chk("full_count", bus.count, 16);
        chk("full_wr_ready", bus.wr_ready, 0);
        drive(0, 0, 1, 0);
        chk("full_no17", bus.count, 16);
        drive(0, 0, 0, 0);
        chk("full_pop_count", bus.count, 15);
        chk("full_reopen", bus.wr_ready, 1);
        repeat (20) drive(0, 0, 1, 0);

        // Streaming 0..99 at one word per cycle
        obs_d.delete();
        obs_c.delete();
        first = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, i, 1, 0);
            if (i == 0) first = cyc + 1;
        end
        repeat (8) drive(0, 0, 1, 0);
        chk("stream_n", obs_d.size(), 100);
        if (obs_d.size() == 100) begin
            bad = 0;
            for (int i = 0; i < 100; i++) if (obs_d[i] !== i) bad++;
            chk("stream_order", bad, 0);
            chk("stream_first_lat", obs_c[0] - first, 3);
            chk("stream_last", obs_c[99] - first, 102);
        end

        // Clear with 7 words held and a RAM read in flight
        repeat (7) drive(1, $urandom, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        drive(1, $urandom, 1, 0);
        drive(0, 0, 0, 1);
        chk("clr_pre_count", bus.count, 7);
        drive(0, 0, 0, 0);
        chk("clr_count", bus.count, 0);
        chk("clr_rd_valid", bus.rd_valid, 0);
        chk("clr_wr_ready", bus.wr_ready, 1);
        drive(1, 32'h55, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        chk("clr_55_valid", bus.rd_valid, 1);
        chk("clr_55_dout", bus.rd_dout, 32'h55);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        // Random traffic with rare clears
        pushes = 0;
        cycles = 0;
        while (pushes < 2000 && cycles < 12000) begin
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), ($urandom_range(0, 299) == 0));
            if (bus.wr_valid && bus.wr_ready && !bus.clear) pushes++;
            cycles++;
        end
        chk("random_budget", pushes >= 2000, 1);
        repeat (20) drive(0, 0, 1, 0);

        // Asynchronous reset mid-stream
        repeat (10) drive(1, $urandom, $urandom_range(0, 1), 0);
        @(negedge clk);
        #3;
        nreset = 1'b0;
        #1;
        chk("arst_wr_ready", bus.wr_ready, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_rd_dout", bus.rd_dout, 0);
        repeat (2) @(negedge clk);
        #3;
        nreset = 1'b1;
        repeat (300) drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 0);
        repeat (20) drive(0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
